db_fetch_ctrl: RTL and testbench
================================

DB_FETCH_CTRL -- requirements
Module: db_fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 512, DDR word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, DDR byte-address width.
REQ-003 SHALL have parameter CNT_W, default 17, database word-index width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, prefetch buffer depth.
REQ-005 SHALL have ports: clk input 1, sole clock; rst input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start input 1; base_addr input ADDR_W; num_words input CNT_W; busy output 1; done output 1, one-cycle pulse.
REQ-007 SHALL have ports: abort input 1, which cancels the stream.
REQ-008 SHALL have ports: ddr_rd output 1; readAdd output ADDR_W; ddr_rd_valid input 1; ddr_rd_done input 1; ddr_rd_data input DATA_W.
REQ-009 SHALL have ports: db_valid output 1; db_ready input 1; db_data output DATA_W; db_index output CNT_W; db_last output 1.
REQ-010 SHALL have ports: exp_req input 1; exp_addr input ADDR_W; exp_valid output 1, one-cycle pulse; exp_data output DATA_W.

Function
REQ-011 SHALL stream words idx 0..num_words-1 from byte address base_addr + idx*(DATA_W/8), computed mod 2^ADDR_W.
REQ-012 SHALL sample start only in IDLE; start with num_words==0 SHALL pulse done the next cycle and stay IDLE.
REQ-013 SHALL use the FSM states IDLE, ARB, WAIT_S, WAIT_E.
- IDLE -> ARB on start.
- ARB -> WAIT_E if exp_req.
- else ARB -> WAIT_S if words remain and fifo_count+1 <= FIFO_DEPTH.
- WAIT_S/WAIT_E -> ARB on ddr_rd_valid & ddr_rd_done.
REQ-014 SHALL assert ddr_rd for exactly one cycle, on the ARB->WAIT transition, with readAdd valid on that cycle and held until completion.
REQ-015 SHALL allow at most one DDR read outstanding.
REQ-016 SHALL give expand reads strict priority over stream reads at ARB; an in-flight stream read SHALL finish first.
REQ-017 SHALL, on WAIT_E completion, register ddr_rd_data to exp_data and pulse exp_valid one cycle later; exp_req SHALL be held until exp_valid.
REQ-018 SHALL, on WAIT_S completion, push ddr_rd_data and its index into the FIFO in the same cycle.
REQ-019 SHALL present the FIFO head on db_data/db_index when db_valid=1.
- Pop on db_valid & db_ready.
- db_last=1 when db_index==num_words-1.
- Push to an empty FIFO gives db_valid the next cycle.
REQ-020 SHALL handle a simultaneous push and pop with fifo_count unchanged; the FIFO SHALL never overflow or underflow.
REQ-021 SHALL pulse done the cycle after the last word is popped, then return to IDLE.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL handle abort as follows:
- Flush the FIFO and deassert db_valid the next cycle.
- Issue no new stream reads.
- Discard any in-flight stream read's data on completion.
- Serve a pending expand read normally.
- Return to IDLE with no done pulse.
REQ-024 SHALL ignore start while busy=1.

Reset
REQ-025 SHALL, on rst=0, set state IDLE and clear ddr_rd, readAdd, busy, done, db_valid, db_index, db_last, exp_valid, the FIFO pointers and the counters asynchronously; data registers need not reset.
REQ-026 SHALL, on reset mid-read, drop the outstanding DDR response; after release the block SHALL ignore ddr_rd_valid until its next ddr_rd.

Structure
REQ-027 SHALL place the FSM state encoding and default widths (512/32/17) in a shared package db_pkg.
REQ-028 SHALL implement the prefetch buffer as one sub-module db_fifo (DATA_W+CNT_W wide, FIFO_DEPTH deep, count output).

Verification
REQ-029 SHALL cover: base_addr=0x1000, num_words=3, db_ready=1 -> readAdd 0x1000, 0x1040, 0x1080; db_index 0,1,2; db_last on index 2; one done pulse.
REQ-030 SHALL cover: num_words=8, FIFO_DEPTH=4, db_ready=0 -> exactly 4 reads issued then stall; db_ready=1 resumes; all 8 words delivered in order.
REQ-031 SHALL cover: exp_req with exp_addr=0x8000 raised during WAIT_S -> stream read completes; next ddr_rd has readAdd=0x8000; exp_valid pulses with the matching data; the stream then continues.
REQ-032 SHALL cover: abort during WAIT_S with 2 words buffered -> db_valid=0 next cycle; in-flight data discarded; IDLE; no done pulse.
REQ-033 SHALL cover: start with num_words=0 -> no ddr_rd; done one cycle later.
REQ-034 SHALL cover: rst=0 asserted in WAIT_S -> all outputs cleared immediately; a late ddr_rd_valid after release produces no push.

Source files
------------

// File: rtl/db_pkg.sv
// Shared definitions for the database fetch controller: default widths and FSM encoding.
package db_pkg;

    localparam int DB_DATA_W = 512;
    localparam int DB_ADDR_W = 32;
    localparam int DB_CNT_W  = 17;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARB    = 2'd1;
    localparam logic [1:0] WAIT_S = 2'd2;
    localparam logic [1:0] WAIT_E = 2'd3;

endpackage

// File: rtl/db_fifo.sv
// Prefetch buffer: synchronous FIFO with occupancy count and flush.
module db_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign doPush  = push & ~full;
    assign doPop   = pop & ~empty;
    assign popData = mem[rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/db_fetch_ctrl.sv
// Streams a database region from DDR into a prefetch FIFO, with priority expand reads
// sharing the single outstanding-read DDR port.
module db_fetch_ctrl
    import db_pkg::*;
#(
    parameter int DATA_W     = DB_DATA_W,
    parameter int ADDR_W     = DB_ADDR_W,
    parameter int CNT_W      = DB_CNT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    input  logic              abort,
    output logic              ddr_rd,
    output logic [ADDR_W-1:0] readAdd,
    input  logic              ddr_rd_valid,
    input  logic              ddr_rd_done,
    input  logic [DATA_W-1:0] ddr_rd_data,
    output logic              db_valid,
    input  logic              db_ready,
    output logic [DATA_W-1:0] db_data,
    output logic [CNT_W-1:0]  db_index,
    output logic              db_last,
    input  logic              exp_req,
    input  logic [ADDR_W-1:0] exp_addr,
    output logic              exp_valid,
    output logic [DATA_W-1:0] exp_data
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int CNT_FW     = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]              state;
    logic [1:0]              stateNext;
    logic [CNT_W-1:0]        numWordsQ;
    logic [CNT_W-1:0]        issueIdx;
    logic [ADDR_W-1:0]       nextAddr;
    logic                    aborting;
    logic                    lastPopped;
    logic [CNT_FW-1:0]       fifoCount;
    logic                    fifoEmpty;
    logic [DATA_W+CNT_W-1:0] fifoHead;
    logic [CNT_W-1:0]        headIdx;
    logic                    abortNow;
    logic                    rdComplete;
    logic                    wordsRemain;
    logic                    hasRoom;
    logic                    expPending;
    logic                    pushFire;
    logic                    popFire;
    logic                    lastPop;

    // abort takes effect in the cycle it is raised and sticks until IDLE
    assign abortNow    = (state != IDLE) & (aborting | abort);
    assign rdComplete  = ddr_rd_valid & ddr_rd_done;
    assign wordsRemain = issueIdx < numWordsQ;
    assign hasRoom     = fifoCount < CNT_FW'(FIFO_DEPTH);
    // exp_req is still high in the exp_valid cycle; don't reissue it
    assign expPending  = exp_req & ~exp_valid;
    assign pushFire    = (state == WAIT_S) & rdComplete & ~abortNow;
    assign popFire     = db_valid & db_ready;
    assign lastPop     = popFire & db_last & ~abortNow;

    assign busy     = (state != IDLE);
    assign db_valid = ~fifoEmpty;
    assign headIdx  = fifoHead[CNT_W-1:0];
    assign db_data  = fifoHead[DATA_W+CNT_W-1:CNT_W];
    assign db_index = db_valid ? headIdx : '0;
    assign db_last  = db_valid & (headIdx == numWordsQ - CNT_W'(1));

    db_fifo #(
        .WIDTH (DATA_W + CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (abortNow),
        .push     (pushFire),
        .pushData ({ddr_rd_data, issueIdx}),
        .pop      (popFire),
        .popData  (fifoHead),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start && num_words != '0) stateNext = ARB;
            end
            ARB: begin
                if (expPending)                               stateNext = WAIT_E;
                else if (abortNow || lastPop || lastPopped)   stateNext = IDLE;
                else if (wordsRemain && hasRoom)              stateNext = WAIT_S;
            end
            WAIT_S, WAIT_E: begin
                if (rdComplete) stateNext = ARB;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ddr_rd     <= 1'b0;
            readAdd    <= '0;
            done       <= 1'b0;
            exp_valid  <= 1'b0;
            numWordsQ  <= '0;
            issueIdx   <= '0;
            nextAddr   <= '0;
            aborting   <= 1'b0;
            lastPopped <= 1'b0;
        end else begin
            state     <= stateNext;
            ddr_rd    <= 1'b0;
            done      <= 1'b0;
            exp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    aborting   <= 1'b0;
                    lastPopped <= 1'b0;
                    if (start) begin
                        numWordsQ <= num_words;
                        issueIdx  <= '0;
                        nextAddr  <= base_addr;
                        done      <= (num_words == '0);
                    end
                end
                ARB: begin
                    if (stateNext == WAIT_E) begin
                        ddr_rd  <= 1'b1;
                        readAdd <= exp_addr;
                    end else if (stateNext == WAIT_S) begin
                        ddr_rd  <= 1'b1;
                        readAdd <= nextAddr;
                    end
                end
                WAIT_S: begin
                    if (pushFire) begin
                        issueIdx <= issueIdx + CNT_W'(1);
                        nextAddr <= nextAddr + ADDR_W'(WORD_BYTES);
                    end
                end
                WAIT_E: begin
                    if (rdComplete) exp_valid <= 1'b1;
                end
                default: ;
            endcase
            if (abortNow) aborting <= 1'b1;
            if (lastPop) begin
                lastPopped <= 1'b1;
                done       <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == WAIT_E && rdComplete) exp_data <= ddr_rd_data;
    end

endmodule

// File: tb/tb_db_fetch_ctrl.sv
// Directed self-checking bench for db_fetch_ctrl with a latency-programmable DDR responder.
module tb_db_fetch_ctrl;

    localparam int DW = 512;
    localparam int AW = 32;
    localparam int CW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic          busy;
    logic          done;
    logic          abort = 1'b0;
    logic          ddr_rd;
    logic [AW-1:0] readAdd;
    logic          ddr_rd_valid;
    logic          ddr_rd_done;
    logic [DW-1:0] ddr_rd_data;
    logic          db_valid;
    logic          db_ready = 1'b0;
    logic [DW-1:0] db_data;
    logic [CW-1:0] db_index;
    logic          db_last;
    logic          exp_req = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic          exp_valid;
    logic [DW-1:0] exp_data;

    int nChecks = 0;
    int nPass = 0;

    int            doneCnt = 0;
    int            expCnt = 0;
    logic [DW-1:0] expDataSeen;
    logic [AW-1:0] rdLog[$];
    logic [CW-1:0] popIdx[$];
    logic [DW-1:0] popDat[$];
    logic          popLast[$];

    int            ddrLat = 1;
    int            injectReq = 0;
    int            injectAck = 0;
    int            rspCnt = 0;
    logic [AW-1:0] rspAddr;

    db_fetch_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .CNT_W      (CW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .abort        (abort),
        .ddr_rd       (ddr_rd),
        .readAdd      (readAdd),
        .ddr_rd_valid (ddr_rd_valid),
        .ddr_rd_done  (ddr_rd_done),
        .ddr_rd_data  (ddr_rd_data),
        .db_valid     (db_valid),
        .db_ready     (db_ready),
        .db_data      (db_data),
        .db_index     (db_index),
        .db_last      (db_last),
        .exp_req      (exp_req),
        .exp_addr     (exp_addr),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkData(input logic [AW-1:0] a);
        logic [AW-1:0] w;
        w = a ^ 32'hA5A5_0000;
        return {16{w}};
    endfunction

    // DDR responder: answers each ddr_rd after ddrLat cycles; forgets pending reads on reset
    always @(negedge clk) begin
        ddr_rd_valid = 1'b0;
        ddr_rd_done  = 1'b0;
        if (!rst) begin
            rspCnt = 0;
        end else begin
            if (injectReq != injectAck) begin
                injectAck    = injectReq;
                ddr_rd_valid = 1'b1;
                ddr_rd_done  = 1'b1;
                ddr_rd_data  = mkData(32'hDEAD_0000);
            end else if (rspCnt > 0) begin
                rspCnt--;
                if (rspCnt == 0) begin
                    ddr_rd_valid = 1'b1;
                    ddr_rd_done  = 1'b1;
                    ddr_rd_data  = mkData(rspAddr);
                end
            end
            if (ddr_rd) begin
                rdLog.push_back(readAdd);
                rspAddr = readAdd;
                rspCnt  = ddrLat;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (done) doneCnt++;
            if (exp_valid) begin
                expCnt++;
                expDataSeen = exp_data;
            end
            if (db_valid && db_ready) begin
                popIdx.push_back(db_index);
                popDat.push_back(db_data);
                popLast.push_back(db_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [AW-1:0] base, input logic [CW-1:0] n);
        base_addr = base;
        num_words = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        int d0;
        d0 = doneCnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (doneCnt != d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        nChecks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else nPass++;
        nChecks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else nPass++;
        nChecks++; if (ddr_rd !== 1'b0) $display("FAIL reset_ddr_rd: got %b want 0", ddr_rd); else nPass++;
        nChecks++; if (readAdd !== '0) $display("FAIL reset_readAdd: got %h want 0", readAdd); else nPass++;
        nChecks++; if ({db_valid, db_last, exp_valid} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {db_valid, db_last, exp_valid}); else nPass++;
        nChecks++; if (db_index !== '0) $display("FAIL reset_db_index: got %h want 0", db_index); else nPass++;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int r0, p0, d0;
        bit ok;
        r0 = rdLog.size(); p0 = popIdx.size(); d0 = doneCnt;
        ddrLat = 1; db_ready = 1'b1;
        pulseStart(32'h1000, 17'd3);
        waitDone(200, ok);
        nChecks++; if (!ok) $display("FAIL basic_done_timeout: got none want done"); else nPass++;
        repeat (3) tick();
        nChecks++; if (rdLog.size() - r0 != 3) $display("FAIL basic_nreads: got %0d want 3", rdLog.size() - r0); else nPass++;
        nChecks++; if (rdLog[r0] !== 32'h1000) $display("FAIL basic_addr0: got %h want 1000", rdLog[r0]); else nPass++;
        nChecks++; if (rdLog[r0+1] !== 32'h1040) $display("FAIL basic_addr1: got %h want 1040", rdLog[r0+1]); else nPass++;
        nChecks++; if (rdLog[r0+2] !== 32'h1080) $display("FAIL basic_addr2: got %h want 1080", rdLog[r0+2]); else nPass++;
        for (int i = 0; i < 3; i++) begin
            nChecks++; if (popIdx[p0+i] !== CW'(i))
                $display("FAIL basic_index%0d: got %0d want %0d", i, popIdx[p0+i], i); else nPass++;
            nChecks++; if (popLast[p0+i] !== (i == 2))
                $display("FAIL basic_last%0d: got %b want %b", i, popLast[p0+i], (i == 2)); else nPass++;
        end
        nChecks++; if (popDat[p0+1] !== mkData(32'h1040)) $display("FAIL basic_data1: got %h want %h",
            popDat[p0+1][31:0], mkData(32'h1040)); else nPass++;
        nChecks++; if (doneCnt - d0 != 1) $display("FAIL basic_done_count: got %0d want 1", doneCnt - d0); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("FAIL basic_idle: got busy=%b want 0", busy); else nPass++;
    endtask

    task automatic test_backpressure();
        int r0, p0, d0;
        bit ok;
        r0 = rdLog.size(); p0 = popIdx.size(); d0 = doneCnt;
        ddrLat = 1; db_ready = 1'b0;
        pulseStart(32'h2000, 17'd8);
        repeat (10) tick();
        pulseStart(32'h9000, 17'd1);  // busy: must be ignored
        repeat (30) tick();
        nChecks++; if (rdLog.size() - r0 != 4) $display("FAIL bp_stall_reads: got %0d want 4", rdLog.size() - r0); else nPass++;
        nChecks++; if (db_valid !== 1'b1 || db_index !== '0)
            $display("FAIL bp_head: got valid=%b idx=%0d want 1/0", db_valid, db_index); else nPass++;
        nChecks++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else nPass++;
        db_ready = 1'b1;
        waitDone(300, ok);
        nChecks++; if (!ok) $display("FAIL bp_done_timeout: got none want done"); else nPass++;
        repeat (3) tick();
        nChecks++; if (rdLog.size() - r0 != 8) $display("FAIL bp_nreads: got %0d want 8", rdLog.size() - r0); else nPass++;
        nChecks++; if (rdLog[r0+7] !== 32'h21C0) $display("FAIL bp_addr7: got %h want 21c0", rdLog[r0+7]); else nPass++;
        nChecks++; if (popIdx.size() - p0 != 8) $display("FAIL bp_npops: got %0d want 8", popIdx.size() - p0); else nPass++;
        for (int i = 0; i < 8; i++) begin
            nChecks++; if (popIdx[p0+i] !== CW'(i))
                $display("FAIL bp_order%0d: got %0d want %0d", i, popIdx[p0+i], i); else nPass++;
        end
        nChecks++; if (popDat[p0+7] !== mkData(32'h21C0)) $display("FAIL bp_data7: got %h want %h",
            popDat[p0+7][31:0], mkData(32'h21C0)); else nPass++;
        nChecks++; if (doneCnt - d0 != 1) $display("FAIL bp_done_count: got %0d want 1", doneCnt - d0); else nPass++;
    endtask

    task automatic test_expand();
        int r0, p0, d0, e0;
        bit ok;
        r0 = rdLog.size(); p0 = popIdx.size(); d0 = doneCnt; e0 = expCnt;
        ddrLat = 4; db_ready = 1'b1;
        pulseStart(32'h3000, 17'd3);
        for (int i = 0; i < 50 && rdLog.size() == r0; i++) tick();
        exp_addr = 32'h8000;
        exp_req  = 1'b1;
        for (int i = 0; i < 100 && !exp_valid; i++) tick();
        nChecks++; if (exp_valid !== 1'b1) $display("FAIL exp_valid_timeout: got %b want 1", exp_valid); else nPass++;
        exp_req = 1'b0;
        waitDone(200, ok);
        nChecks++; if (!ok) $display("FAIL exp_done_timeout: got none want done"); else nPass++;
        repeat (3) tick();
        nChecks++; if (rdLog[r0] !== 32'h3000) $display("FAIL exp_addr0: got %h want 3000", rdLog[r0]); else nPass++;
        nChecks++; if (rdLog[r0+1] !== 32'h8000) $display("FAIL exp_addr1: got %h want 8000", rdLog[r0+1]); else nPass++;
        nChecks++; if (rdLog[r0+2] !== 32'h3040) $display("FAIL exp_addr2: got %h want 3040", rdLog[r0+2]); else nPass++;
        nChecks++; if (rdLog.size() - r0 != 4) $display("FAIL exp_nreads: got %0d want 4", rdLog.size() - r0); else nPass++;
        nChecks++; if (expCnt - e0 != 1) $display("FAIL exp_pulses: got %0d want 1", expCnt - e0); else nPass++;
        nChecks++; if (expDataSeen !== mkData(32'h8000)) $display("FAIL exp_data: got %h want %h",
            expDataSeen[31:0], mkData(32'h8000)); else nPass++;
        nChecks++; if (popIdx.size() - p0 != 3 || popIdx[p0+2] !== CW'(2))
            $display("FAIL exp_stream: got %0d pops want 3", popIdx.size() - p0); else nPass++;
        nChecks++; if (doneCnt - d0 != 1) $display("FAIL exp_done_count: got %0d want 1", doneCnt - d0); else nPass++;
    endtask

    task automatic test_abort();
        int r0, p0, d0;
        r0 = rdLog.size(); p0 = popIdx.size(); d0 = doneCnt;
        ddrLat = 3; db_ready = 1'b0;
        pulseStart(32'h4000, 17'd8);
        for (int i = 0; i < 100 && rdLog.size() - r0 < 3; i++) tick();
        nChecks++; if (db_valid !== 1'b1) $display("FAIL abort_pre_valid: got %b want 1", db_valid); else nPass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nChecks++; if (db_valid !== 1'b0) $display("FAIL abort_flush: got %b want 0", db_valid); else nPass++;
        repeat (30) tick();
        nChecks++; if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy); else nPass++;
        nChecks++; if (db_valid !== 1'b0) $display("FAIL abort_discard: got %b want 0", db_valid); else nPass++;
        nChecks++; if (rdLog.size() - r0 != 3) $display("FAIL abort_nreads: got %0d want 3", rdLog.size() - r0); else nPass++;
        nChecks++; if (doneCnt != d0) $display("FAIL abort_no_done: got %0d want 0", doneCnt - d0); else nPass++;
        nChecks++; if (popIdx.size() != p0) $display("FAIL abort_no_pop: got %0d want 0", popIdx.size() - p0); else nPass++;
    endtask

    task automatic test_zero();
        int r0;
        r0 = rdLog.size();
        ddrLat = 1; db_ready = 1'b1;
        pulseStart(32'h7000, 17'd0);
        nChecks++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else nPass++;
        tick();
        nChecks++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else nPass++;
        repeat (4) tick();
        nChecks++; if (rdLog.size() != r0) $display("FAIL zero_no_read: got %0d want 0", rdLog.size() - r0); else nPass++;
    endtask

    task automatic test_reset_mid();
        int r0, p0;
        r0 = rdLog.size(); p0 = popIdx.size();
        ddrLat = 10; db_ready = 1'b1;
        pulseStart(32'h5000, 17'd2);
        for (int i = 0; i < 50 && rdLog.size() == r0; i++) tick();
        nChecks++; if (readAdd !== 32'h5000) $display("FAIL rmid_pre_addr: got %h want 5000", readAdd); else nPass++;
        rst = 1'b0;
        #1;
        nChecks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else nPass++;
        nChecks++; if (readAdd !== '0) $display("FAIL rmid_readAdd: got %h want 0", readAdd); else nPass++;
        nChecks++; if ({ddr_rd, done, db_valid, exp_valid} !== 4'b0000)
            $display("FAIL rmid_flags: got %b want 0000", {ddr_rd, done, db_valid, exp_valid}); else nPass++;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        injectReq++;
        repeat (5) tick();
        nChecks++; if (db_valid !== 1'b0) $display("FAIL rmid_late_push: got %b want 0", db_valid); else nPass++;
        nChecks++; if (popIdx.size() != p0) $display("FAIL rmid_no_pop: got %0d want 0", popIdx.size() - p0); else nPass++;
        nChecks++; if (busy !== 1'b0 || rdLog.size() - r0 != 1)
            $display("FAIL rmid_quiet: got busy=%b reads=%0d want 0/1", busy, rdLog.size() - r0); else nPass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        repeat (3) tick();
        test_backpressure();
        repeat (3) tick();
        test_expand();
        repeat (3) tick();
        test_abort();
        repeat (3) tick();
        test_zero();
        repeat (3) tick();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
